// File: rtl/lsu_if.sv
// Core-side and memory-side signal bundle of the load/store unit.
// Handshakes: a core op transfers on the clk edge where req_valid and
// req_ready are both high; resp_valid is a single-cycle pulse with no
// back-pressure.
// A memory access is presented while mem_req is high, and every mem_*
// output holds steady until the edge where mem_ack is high. mem_rdata is
// sampled on that same edge.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        is_store;
   logic [1:0]  width;
   logic        sign_ext;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   // The LSU side of the bundle.
   modport slave (
      input  req_valid, addr, wdata, is_store, width, sign_ext, mem_ack, mem_rdata,
      output req_ready, resp_valid, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   // The core/memory side of the bundle.
   modport master (
      output req_valid, addr, wdata, is_store, width, sign_ext, mem_ack, mem_rdata,
      input  req_ready, resp_valid, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit. It takes the ALU result as the effective address
// and drives a word-wide memory port with byte enables. An access that
// crosses a word boundary becomes two word accesses (low word first).
// The load result is sign- or zero-extended before it is returned.
module lsu #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   lsu_if.slave       bus,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

   state_t      state, state_n;
   logic [31:0] addr_q, wdata_q, lo_q, rdata_q;
   logic        store_q, sext_q, err_q;
   logic [1:0]  width_q;

   // A half at offset 3, or a word at any non-zero offset, spills into the next word.
   function automatic logic crosses(input logic [1:0] o, input logic [1:0] w);
      return (w == 2'b01 && o == 2'b11) || (w == 2'b10 && o != 2'b00);
   endfunction

   logic [1:0]  offs;
   logic        split;
   logic [3:0]  mask;
   logic [7:0]  lanes;
   logic [31:0] wd_acc0, wd_acc1, word_base;
   logic        accept, accept_err;
   logic [31:0] lo_n, hi_n, raw, load_data, rdata_n;
   logic [63:0] pair;

   assign offs      = addr_q[1:0];
   assign split     = crosses(offs, width_q);
   assign word_base = {addr_q[31:2], 2'b00};
   assign lanes     = {4'b0000, mask} << offs;
   assign wd_acc0   = wdata_q << {offs, 3'b000};
   assign wd_acc1   = (offs == 2'b00) ? 32'd0 : (wdata_q >> (6'd32 - {1'b0, offs, 3'b000}));
   assign accept    = bus.req_valid && (state == IDLE);
   assign accept_err = (bus.width == 2'b11) ||
                       (!ALLOW_MISALIGNED && crosses(bus.addr[1:0], bus.width));

   // Byte-lane mask before it is shifted into position.
   always_comb begin
      case (width_q)
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
   end

   // Form the load result from the words that will be held once the current ack lands.
   always_comb begin
      lo_n = bus.mem_rdata;
      hi_n = 32'd0;
      if (state == ACC1) begin
         lo_n = lo_q;
         hi_n = bus.mem_rdata;
      end
      pair = {hi_n, lo_n} >> {offs, 3'b000};
      raw  = pair[31:0];
      case (width_q)
         2'b00:   load_data = {{24{sext_q & raw[7]}}, raw[7:0]};
         2'b01:   load_data = {{16{sext_q & raw[15]}}, raw[15:0]};
         default: load_data = raw;
      endcase
      rdata_n = store_q ? 32'd0 : load_data;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state and all handshake/memory outputs. The memory outputs are zero unless mem_req is high.
   always_comb begin
      state_n        = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = 32'd0;
      bus.mem_be     = 4'd0;
      bus.mem_wdata  = 32'd0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_n = accept_err ? RESP : ACC0;
         end
         ACC0: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = store_q;
            bus.mem_addr  = word_base;
            bus.mem_be    = lanes[3:0];
            bus.mem_wdata = wd_acc0;
            if (bus.mem_ack) state_n = split ? ACC1 : RESP;
         end
         ACC1: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = store_q;
            bus.mem_addr  = word_base + 32'd4;
            bus.mem_be    = lanes[7:4];
            bus.mem_wdata = wd_acc1;
            if (bus.mem_ack) state_n = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            state_n        = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Op capture, low-word capture, and the result registers that take their values on entry to RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         store_q <= 1'b0;
         width_q <= 2'b00;
         sext_q  <= 1'b0;
         lo_q    <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            store_q <= bus.is_store;
            width_q <= bus.width;
            sext_q  <= bus.sign_ext;
            if (accept_err) begin
               rdata_q <= 32'd0;
               err_q   <= 1'b1;
            end
         end
         if (state == ACC0 && bus.mem_ack) begin
            lo_q <= bus.mem_rdata;
            if (!split) begin
               rdata_q <= rdata_n;
               err_q   <= 1'b0;
            end
         end
         if (state == ACC1 && bus.mem_ack) begin
            rdata_q <= rdata_n;
            err_q   <= 1'b0;
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.err   = err_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu. One instance splits misaligned accesses and is
// driven from a vector table plus a reset-abort sequence. A second
// instance rejects misaligned accesses and has an always-acking memory.
module tb_lsu;

   logic clk = 1'b0;
   logic reset;
   logic [1:0] st0, st1;
   int cyc = 0;
   int req_cnt0 = 0;
   int req_cnt1 = 0;
   int n_cmp = 0;
   int n_fail = 0;

   lsu_if if0();
   lsu_if if1();

   lsu #(.ALLOW_MISALIGNED(1'b1)) u0 (.clk(clk), .reset(reset), .bus(if0), .dbg_state(st0));
   lsu #(.ALLOW_MISALIGNED(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1), .dbg_state(st1));

   assign if1.mem_ack   = if1.mem_req;
   assign if1.mem_rdata = 32'hCAFE_F00D;

   // Clock and reference cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory request-cycle monitors
   always @(negedge clk) begin
      if (if0.mem_req) req_cnt0 = req_cnt0 + 1;
      if (if1.mem_req) req_cnt1 = req_cnt1 + 1;
   end

   typedef struct {
      logic        st;
      logic [1:0]  w;
      logic        se;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] m0;
      logic [31:0] m1;
      int          dly;
      int          nacc;
      logic [31:0] a0;
      logic [3:0]  be0;
      logic [31:0] wd0;
      logic [31:0] a1;
      logic [3:0]  be1;
      logic [31:0] wd1;
      logic [31:0] rd;
      logic        er;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_access(input int i, input int k, input vec_t v);
      int n;
      logic [31:0] ea, ew;
      logic [3:0]  eb;
      ea = (k == 0) ? v.a0 : v.a1;
      eb = (k == 0) ? v.be0 : v.be1;
      ew = (k == 0) ? v.wd0 : v.wd1;
      n = 0;
      @(negedge clk);
      while (!if0.mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("v%0d_a%0d_mem_req", i, k), 32'(if0.mem_req), 32'd1);
      chk($sformatf("v%0d_a%0d_mem_addr", i, k), if0.mem_addr, ea);
      chk($sformatf("v%0d_a%0d_mem_be", i, k), 32'(if0.mem_be), 32'(eb));
      chk($sformatf("v%0d_a%0d_mem_wdata", i, k), if0.mem_wdata, ew);
      chk($sformatf("v%0d_a%0d_mem_we", i, k), 32'(if0.mem_we), 32'(v.st));
      for (int d = 0; d < v.dly; d++) begin
         @(negedge clk);
         chk($sformatf("v%0d_a%0d_hold_req", i, k), 32'(if0.mem_req), 32'd1);
         chk($sformatf("v%0d_a%0d_hold_addr", i, k), if0.mem_addr, ea);
         chk($sformatf("v%0d_a%0d_hold_be", i, k), 32'(if0.mem_be), 32'(eb));
      end
      if0.mem_ack   = 1'b1;
      if0.mem_rdata = (k == 0) ? v.m0 : v.m1;
      @(posedge clk);
      #1;
      if0.mem_ack   = 1'b0;
      if0.mem_rdata = 32'd0;
   endtask

   task automatic do_op(input int i, input vec_t v);
      int c_e, r0, n;
      @(negedge clk);
      if0.req_valid = 1'b1;
      if0.addr      = v.addr;
      if0.wdata     = v.wd;
      if0.is_store  = v.st;
      if0.width     = v.w;
      if0.sign_ext  = v.se;
      chk($sformatf("v%0d_req_ready", i), 32'(if0.req_ready), 32'd1);
      @(posedge clk);
      #1;
      c_e = cyc;
      r0  = req_cnt0;
      if0.req_valid = 1'b0;
      if0.addr      = 32'd0;
      if0.wdata     = 32'd0;
      for (int k = 0; k < v.nacc; k++) do_access(i, k, v);
      n = 0;
      @(negedge clk);
      while (!if0.resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("v%0d_resp_valid", i), 32'(if0.resp_valid), 32'd1);
      chk($sformatf("v%0d_latency", i), 32'(cyc - c_e + 1), 32'(v.lat));
      chk($sformatf("v%0d_rdata", i), if0.rdata, v.rd);
      chk($sformatf("v%0d_err", i), 32'(if0.err), 32'(v.er));
      chk($sformatf("v%0d_busy", i), 32'(if0.req_ready), 32'd0);
      chk($sformatf("v%0d_req_cycles", i), 32'(req_cnt0 - r0), 32'(v.nacc * (v.dly + 1)));
      @(negedge clk);
      chk($sformatf("v%0d_resp_pulse", i), 32'(if0.resp_valid), 32'd0);
      chk($sformatf("v%0d_rdata_held", i), if0.rdata, v.rd);
      chk($sformatf("v%0d_err_held", i), 32'(if0.err), 32'(v.er));
   endtask

   task automatic op1(input string name, input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      input int exp_reqs);
      int c_e, r0, n;
      @(negedge clk);
      if1.req_valid = 1'b1;
      if1.addr      = a;
      if1.width     = w;
      if1.is_store  = 1'b0;
      if1.sign_ext  = 1'b1;
      @(posedge clk);
      #1;
      c_e = cyc;
      r0  = req_cnt1;
      if1.req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!if1.resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_resp_valid"}, 32'(if1.resp_valid), 32'd1);
      chk({name, "_latency"}, 32'(cyc - c_e + 1), 32'(exp_lat));
      chk({name, "_rdata"}, if1.rdata, exp_rd);
      chk({name, "_err"}, 32'(if1.err), 32'(exp_err));
      chk({name, "_req_cycles"}, 32'(req_cnt1 - r0), 32'(exp_reqs));
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Main sequence
   initial begin
      int resp_seen;
      //            st  w      se  addr           wd             m0             m1             dly n  a0             be0      wd0            a1             be1      wd1            rd             er  lat
      vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 32'h0,         0, 1, 32'h0000_1000, 4'b1111, 32'h0,         32'h0,         4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
      vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 32'h0,         0, 1, 32'h0000_1000, 4'b1000, 32'h0,         32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80, 1'b0, 2};
      vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 32'h0,         1, 1, 32'h0000_1000, 4'b1000, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1'b0, 3};
      vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        32'h0,         0, 1, 32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0, 2};
      vecs[4]  = '{1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'h0,        32'h0,         32'h0,         0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1};
      vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0,        32'h4433_2211, 32'h8877_6655, 2, 2, 32'h0000_3000, 4'b1110, 32'h0,         32'h0000_3004, 4'b0001, 32'h0,         32'h5544_3322, 1'b0, 7};
      vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h1122_3344, 32'h0,        32'h0,         0, 2, 32'h0000_3000, 4'b1110, 32'h2233_4400, 32'h0000_3004, 4'b0001, 32'h0000_0011, 32'h0,         1'b0, 3};
      vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0,        32'hAABB_CCDD, 32'h1122_3344, 0, 2, 32'hFFFF_FFFC, 4'b1100, 32'h0,         32'h0000_0000, 4'b0011, 32'h0,         32'h3344_AABB, 1'b0, 3};
      vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0FFF, 32'h0,        32'hAB00_0000, 32'h0000_00FF, 1, 2, 32'h0000_0FFC, 4'b1000, 32'h0,         32'h0000_1000, 4'b0001, 32'h0,         32'hFFFF_FFAB, 1'b0, 5};
      vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0,        32'h8001_0000, 32'h0,         1, 1, 32'h0000_1000, 4'b1100, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0000_8001, 1'b0, 3};
      vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_4001, 32'h1234_56A5, 32'h0,        32'h0,         0, 1, 32'h0000_4000, 4'b0010, 32'h3456_A500, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0, 2};
      vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h0000_1001, 32'h0,        32'h00F0_0D00, 32'h0,         0, 1, 32'h0000_1000, 4'b0110, 32'h0,         32'h0,         4'b0000, 32'h0,         32'hFFFF_F00D, 1'b0, 2};
      vecs[12] = '{1'b1, 2'b11, 1'b0, 32'h0000_6000, 32'hFFFF_FFFF, 32'h0,        32'h0,         0, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1};

      reset = 1'b1;
      if0.req_valid = 1'b0; if0.addr = 32'd0; if0.wdata = 32'd0; if0.is_store = 1'b0;
      if0.width = 2'b00; if0.sign_ext = 1'b0; if0.mem_ack = 1'b0; if0.mem_rdata = 32'd0;
      if1.req_valid = 1'b0; if1.addr = 32'd0; if1.wdata = 32'd0; if1.is_store = 1'b0;
      if1.width = 2'b00; if1.sign_ext = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(if0.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(if0.resp_valid), 32'd0);
      chk("rst_rdata", if0.rdata, 32'd0);
      chk("rst_err", 32'(if0.err), 32'd0);
      chk("rst_mem_req", 32'(if0.mem_req), 32'd0);
      chk("rst_mem_we", 32'(if0.mem_we), 32'd0);
      chk("rst_mem_be", 32'(if0.mem_be), 32'd0);
      chk("rst_mem_addr", if0.mem_addr, 32'd0);
      chk("rst_mem_wdata", if0.mem_wdata, 32'd0);
      chk("rst_state", 32'(st0), 32'd0);
      chk("rst1_req_ready", 32'(if1.req_ready), 32'd1);
      chk("rst1_mem_req", 32'(if1.mem_req), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) do_op(i, vecs[i]);

      // Abort a split load in its second access with reset; a late ack must not produce a response.
      @(negedge clk);
      if0.req_valid = 1'b1; if0.addr = 32'h0000_3001; if0.width = 2'b10;
      if0.is_store = 1'b0; if0.sign_ext = 1'b0;
      @(posedge clk);
      #1;
      if0.req_valid = 1'b0;
      @(negedge clk);
      if0.mem_ack = 1'b1; if0.mem_rdata = 32'h4433_2211;
      @(posedge clk);
      #1;
      if0.mem_ack = 1'b0; if0.mem_rdata = 32'd0;
      @(negedge clk);
      chk("abort_acc1_req", 32'(if0.mem_req), 32'd1);
      chk("abort_acc1_addr", if0.mem_addr, 32'h0000_3004);
      chk("abort_acc1_state", 32'(st0), 32'd2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_mem_req", 32'(if0.mem_req), 32'd0);
      chk("abort_req_ready", 32'(if0.req_ready), 32'd1);
      chk("abort_rdata", if0.rdata, 32'd0);
      chk("abort_err", 32'(if0.err), 32'd0);
      if0.mem_ack = 1'b1; if0.mem_rdata = 32'h8877_6655;
      resp_seen = 0;
      @(posedge clk);
      #1;
      if0.mem_ack = 1'b0; if0.mem_rdata = 32'd0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (if0.resp_valid) resp_seen++;
      end
      chk("abort_no_resp", 32'(resp_seen), 32'd0);
      chk("abort_idle", 32'(st0), 32'd0);
      chk("abort_mem_req_after", 32'(if0.mem_req), 32'd0);
      do_op(100, vecs[0]);

      // Misaligned accesses are rejected without touching memory when splitting is disabled.
      op1("nm_lh_0fff", 2'b01, 32'h0000_0FFF, 32'h0, 1'b1, 1, 0);
      op1("nm_width11", 2'b11, 32'h0000_0100, 32'h0, 1'b1, 1, 0);
      op1("nm_lw_aligned", 2'b10, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, 2, 1);
      op1("nm_lw_2001", 2'b10, 32'h0000_2001, 32'h0, 1'b1, 1, 0);
      op1("nm_lh_2002", 2'b01, 32'h0000_2002, 32'hFFFF_CAFE, 1'b0, 2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
